fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/next_pc.sv | 42 ++++
 rtl/fetch.sv | 106 ++++++++++
 tb/tb_fetch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: next-PC select codes, FSM states, reset vector.
`default_nettype none

package fetch_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_REL = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;

  localparam logic [15:0] RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/next_pc.sv
// Next-PC adder/mux. Optional macro FETCH_ALIGN_CHECK_EN flags and clears an odd target.
`default_nettype none

module next_pc
  import fetch_pkg::*;
(
  input  logic [15:0] pc,
  input  logic [1:0]  pc_add,
  input  logic [15:0] imm,
  input  logic [15:0] rs_data,
  output logic [15:0] target,
  output logic        err
);

  logic [15:0] raw;
  logic        illegal;

  always_comb begin
    raw     = pc;
    illegal = 1'b0;
    case (pc_add)
      PC_SEQ:  raw = pc;
      PC_REL:  raw = pc + imm;
      PC_REG:  raw = rs_data + imm;
      default: begin
        raw     = pc;
        illegal = 1'b1;
      end
    endcase
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign target = {raw[15:1], 1'b0};
  assign err    = illegal | raw[0];
`else
  assign target = raw;
  assign err    = illegal;
`endif

endmodule

`default_nettype wire

// File: rtl/fetch.sv
// Instruction fetch stage: REQ/HOLD/HALTED FSM with registered outputs to decode.
`default_nettype none

module fetch
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instruction,
  output logic [15:0] PC,
  output logic        inst_valid,
  input  logic        dec_ready,
  input  logic [1:0]  PC_Add,
  input  logic [15:0] imm,
  input  logic [15:0] Rs_data,
  input  logic        halt,
  output logic        err
);

  state_e      state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_q, pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        req_q, req_d;
  logic        err_q, err_d;

  logic [15:0] target;
  logic        np_err;

  next_pc u_next_pc (
    .pc      (pc_q),
    .pc_add  (PC_Add),
    .imm     (imm),
    .rs_data (Rs_data),
    .target  (target),
    .err     (np_err)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    err_d      = 1'b0;
    case (state_q)
      // req_q gates the response so a stale beat from before reset is dropped
      ST_REQ: begin
        if (imem_valid && req_q) begin
          instr_d = imem_rdata;
          pc_d    = fetch_pc_q + 16'd2;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (dec_ready) begin
          if (halt) begin
            state_d = ST_HALTED;
          end else begin
            fetch_pc_d = target;
            err_d      = np_err;
            state_d    = ST_REQ;
          end
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_REQ;
    endcase
    req_d        = (state_d == ST_REQ);
    inst_valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_REQ;
      fetch_pc_q   <= RESET_PC;
      instr_q      <= 16'h0000;
      pc_q         <= 16'h0000;
      inst_valid_q <= 1'b0;
      req_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      req_q        <= req_d;
      err_q        <= err_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = fetch_pc_q;
  assign instruction = instr_q;
  assign PC          = pc_q;
  assign inst_valid  = inst_valid_q;
  assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch.sv
// Directed bench for fetch: sequential flow, branches, stalls, halt, errors and reset mid-request.
`default_nettype none

module tb_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic [15:0] instruction;
  logic [15:0] PC;
  logic        inst_valid;
  logic        dec_ready = 1'b0;
  logic [1:0]  PC_Add = 2'b00;
  logic [15:0] imm = 16'h0000;
  logic [15:0] Rs_data = 16'h0000;
  logic        halt = 1'b0;
  logic        err;

  // memory model: auto mode answers lat cycles after the request, manual mode is driven directly
  logic        mem_auto = 1'b1;
  logic        man_valid = 1'b0;
  logic [15:0] man_rdata = 16'h0000;
  int          lat = 0;
  int          wait_cnt = 0;
  logic        model_valid;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [15:0] word(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_req && !imem_valid) wait_cnt <= wait_cnt + 1;
    else                         wait_cnt <= 0;
  end

  assign model_valid = imem_req && (wait_cnt >= lat);
  assign imem_valid  = mem_auto ? model_valid : man_valid;
  assign imem_rdata  = mem_auto ? word(imem_addr) : man_rdata;

  fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .PC          (PC),
    .inst_valid  (inst_valid),
    .dec_ready   (dec_ready),
    .PC_Add      (PC_Add),
    .imm         (imm),
    .Rs_data     (Rs_data),
    .halt        (halt),
    .err         (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // called at a negedge in HOLD; decode inputs are scrambled after the accept cycle
  task automatic accept_step(input logic [1:0] sel, input logic [15:0] off, input logic [15:0] rs,
                             input logic [15:0] exp_addr, input logic exp_err, input string tag);
    logic [15:0] exp_pc;
    exp_pc    = exp_addr + 16'd2;
    PC_Add    = sel;
    imm       = off;
    Rs_data   = rs;
    halt      = 1'b0;
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
    PC_Add    = 2'b11;
    imm       = 16'h7777;
    Rs_data   = 16'h3333;
    halt      = 1'b1;
    check({tag, "_req"},  imem_req, 1);
    check({tag, "_addr"}, imem_addr, exp_addr);
    check({tag, "_err"},  err, exp_err);
    @(negedge clk);
    check({tag, "_vld"},  inst_valid, 1);
    check({tag, "_pc"},   PC, exp_pc);
    check({tag, "_ins"},  instruction, word(exp_addr));
    check({tag, "_err0"}, err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_vld", inst_valid, 0);
    check("rst_ins", instruction, 16'h0000);
    check("rst_pc",  PC, 16'h0000);
    check("rst_err", err, 0);

    // zero-wait sequential stream
    dec_ready = 1'b1;
    rst       = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("seq_req",  imem_req, 1);
      check("seq_addr", imem_addr, 16'(2 * k));
      @(negedge clk);
      check("seq_vld", inst_valid, 1);
      check("seq_pc",  PC, 16'(2 * k + 2));
      check("seq_ins", instruction, word(16'(2 * k)));
    end
    dec_ready = 1'b0;

    // stall in HOLD while memory keeps signalling
    mem_auto  = 1'b0;
    man_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      man_rdata = 16'($urandom);
      @(negedge clk);
      check("stall_ins", instruction, word(16'h0004));
      check("stall_pc",  PC, 16'h0006);
      check("stall_req", imem_req, 0);
      check("stall_vld", inst_valid, 1);
    end
    mem_auto  = 1'b1;
    man_valid = 1'b0;

    accept_step(2'b01, 16'h0008, 16'h0000, 16'h000E, 1'b0, "rel_fwd");
    accept_step(2'b01, 16'hFFF8, 16'h0000, 16'h0008, 1'b0, "rel_back");
    accept_step(2'b10, 16'h0004, 16'h1000, 16'h1004, 1'b0, "reg");
    accept_step(2'b11, 16'h1234, 16'h4321, 16'h1006, 1'b1, "illegal");
    accept_step(2'b10, 16'h000E, 16'hFFF0, 16'hFFFE, 1'b0, "top");
    accept_step(2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, "wrap");
    accept_step(2'b10, 16'h0000, 16'h000E, 16'h000E, 1'b0, "to10");
`ifdef FETCH_ALIGN_CHECK_EN
    accept_step(2'b01, 16'h0003, 16'h0000, 16'h0012, 1'b1, "odd");
`else
    accept_step(2'b01, 16'h0003, 16'h0000, 16'h0013, 1'b0, "odd");
`endif

    // halt: nothing moves until reset
    PC_Add    = 2'b00;
    halt      = 1'b1;
    dec_ready = 1'b1;
    @(negedge clk);
    halt      = 1'b0;
    mem_auto  = 1'b0;
    man_valid = 1'b1;
    man_rdata = 16'hCAFE;
    check("halt_err", err, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halted", {imem_req, inst_valid}, 2'b00);
    end
    rst       = 1'b0;
    dec_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("halt_rst_ins", instruction, 16'h0000);
    check("halt_rst_pc",  PC, 16'h0000);
    check("halt_rst_req", imem_req, 0);
    man_valid = 1'b0;
    mem_auto  = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    check("restart_req",  imem_req, 1);
    check("restart_addr", imem_addr, 16'h0000);
    @(negedge clk);
    check("restart_vld", inst_valid, 1);
    check("restart_pc",  PC, 16'h0002);

    // 3-cycle latency, reset while a request is outstanding
    lat       = 3;
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
    check("lat_req",  imem_req, 1);
    check("lat_addr", imem_addr, 16'h0002);
    @(negedge clk);
    check("lat_wait", inst_valid, 0);
    rst       = 1'b0;
    mem_auto  = 1'b0;
    man_valid = 1'b1;
    man_rdata = 16'hDEAD;
    repeat (3) @(negedge clk);
    check("mid_rst_req", imem_req, 0);
    check("mid_rst_ins", instruction, 16'h0000);
    rst = 1'b1;
    @(negedge clk);
    check("stale_req",  imem_req, 1);
    check("stale_addr", imem_addr, 16'h0000);
    check("stale_vld",  inst_valid, 0);
    check("stale_ins",  instruction, 16'h0000);
    mem_auto  = 1'b1;
    man_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!inst_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("lat_timeout", n < 10, 1);
    end
    check("lat_ins", instruction, word(16'h0000));
    check("lat_pc",  PC, 16'h0002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
